// File: rtl/booth_mul.sv
// ---------------------------------------------------------------------------
// booth_mul
//   Sequential signed radix-2 Booth multiplier. The two operands arrive on a
//   shared WIDTH-bit bus on consecutive cycles. The design performs one Booth
//   step per clock. The 2*WIDTH-bit product is returned as two consecutive
//   words, high word first.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   start      in   request, sampled only in IDLE; in_bus holds the
//                   multiplicand in that cycle
//   in_bus     in   [WIDTH-1:0] multiplicand (start cycle), then the
//                   multiplier (next cycle)
//   busy       out  high from the accepting edge until the return to IDLE
//   out_valid  out  out_bus carries a product word
//   out_hi     out  1 = high word, 0 = low word (only meaningful with valid)
//   out_bus    out  [WIDTH-1:0] product word, 0 when out_valid is low
// ---------------------------------------------------------------------------
module booth_mul #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] in_bus,
   output logic             busy,
   output logic             out_valid,
   output logic             out_hi,
   output logic [WIDTH-1:0] out_bus
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_Q = 3'd1,
      CALC   = 3'd2,
      OUT_HI = 3'd3,
      OUT_LO = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH:0]     m_q, m_d;      // sign-extended multiplicand
   logic [WIDTH:0]     a_q, a_d;      // accumulator, one guard bit
   logic [WIDTH-1:0]   q_q, q_d;      // multiplier / low product half
   logic               q1_q, q1_d;    // Booth history bit
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH:0]     a_sum;         // accumulator after the add/sub, before the shift

   // Register all state; reset clears the datapath and returns to IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         m_q     <= {(WIDTH+1){1'b0}};
         a_q     <= {(WIDTH+1){1'b0}};
         q_q     <= {WIDTH{1'b0}};
         q1_q    <= 1'b0;
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         a_q     <= a_d;
         q_q     <= q_d;
         q1_q    <= q1_d;
         cnt_q   <= cnt_d;
      end
   end

   // Booth add/subtract selected by the current pair {Q[0], q_1}.
   // The guard bit keeps A-M representable when M is the most negative value.
   always_comb begin
      a_sum = a_q;
      case ({q_q[0], q1_q})
         2'b01:   a_sum = a_q + m_q;
         2'b10:   a_sum = a_q - m_q;
         default: a_sum = a_q;
      endcase
   end

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      a_d     = a_q;
      q_d     = q_q;
      q1_d    = q1_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               m_d     = {in_bus[WIDTH-1], in_bus};
               a_d     = {(WIDTH+1){1'b0}};
               q1_d    = 1'b0;
               cnt_d   = {CNT_W{1'b0}};
               state_d = LOAD_Q;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD_Q: begin
            q_d     = in_bus;
            state_d = CALC;
         end
         CALC: begin
            // Arithmetic right shift of {A', Q, q_1}.
            a_d   = {a_sum[WIDTH], a_sum[WIDTH:1]};
            q_d   = {a_sum[0], q_q[WIDTH-1:1]};
            q1_d  = q_q[0];
            cnt_d = cnt_q + CNT_W'(1'b1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = OUT_HI;
            end else begin
               state_d = CALC;
            end
         end
         OUT_HI: begin
            state_d = OUT_LO;
         end
         OUT_LO: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Moore output decode from the registered state and A/Q only.
   always_comb begin
      busy      = (state_q != IDLE);
      out_valid = 1'b0;
      out_hi    = 1'b0;
      out_bus   = {WIDTH{1'b0}};
      case (state_q)
         OUT_HI: begin
            out_valid = 1'b1;
            out_hi    = 1'b1;
            out_bus   = a_q[WIDTH-1:0];
         end
         OUT_LO: begin
            out_valid = 1'b1;
            out_hi    = 1'b0;
            out_bus   = q_q;
         end
         default: begin
            out_valid = 1'b0;
            out_hi    = 1'b0;
            out_bus   = {WIDTH{1'b0}};
         end
      endcase
   end

endmodule

// File: tb/tb_booth_mul.sv
// ---------------------------------------------------------------------------
// tb_booth_mul
//   Self-checking bench for booth_mul (WIDTH=8). Expected products come from
//   plain signed integer multiplication.
// ---------------------------------------------------------------------------
module tb_booth_mul;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] in_bus;
   logic       busy;
   logic       out_valid;
   logic       out_hi;
   logic [7:0] out_bus;

   int checks   = 0;
   int failures = 0;

   // Results observed by run_op
   logic [7:0] obs_hi, obs_lo;
   int         hi_cyc, lo_cyc, vcount, busy_cnt;
   logic       busy_end;
   logic       bus_leak;

   booth_mul #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_bus    (in_bus),
      .busy      (busy),
      .out_valid (out_valid),
      .out_hi    (out_hi),
      .out_bus   (out_bus)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
      int p;
      p = int'($signed(a)) * int'($signed(b));
      return p[15:0];
   endfunction

   // Issue one operation. The caller is 1 time unit after a rising edge with
   // the DUT idle. Returns 1 time unit after edge E11. It records the words,
   // the edge index of each valid and the busy profile.
   task automatic run_op(input logic [7:0] m, input logic [7:0] q, input bit hold);
      obs_hi   = 8'h00;
      obs_lo   = 8'h00;
      hi_cyc   = -1;
      lo_cyc   = -1;
      vcount   = 0;
      busy_cnt = 0;
      bus_leak = 1'b0;
      start    = 1'b1;
      in_bus   = m;
      for (int c = 0; c <= 11; c++) begin
         @(posedge clk);
         #1;
         if (c == 0) begin
            in_bus = q;
            start  = hold;
         end else begin
            in_bus = hold ? 8'h11 : 8'($urandom_range(0, 255));
         end
         if (busy) busy_cnt++;
         if (out_valid) begin
            vcount++;
            if (out_hi) begin
               obs_hi = out_bus;
               hi_cyc = c;
            end else begin
               obs_lo = out_bus;
               lo_cyc = c;
            end
         end else if (out_bus !== 8'h00) begin
            bus_leak = 1'b1;
         end
      end
      busy_end = busy | out_valid;
   endtask

   task automatic test_reset;
      rst    = 1'b0;
      start  = 1'b0;
      in_bus = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, out_valid, out_hi, out_bus} !== 11'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=000", {busy, out_valid, out_hi, out_bus});
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_7x3;
      run_op(8'h07, 8'h03, 1'b0);
      checks++;
      if (obs_hi !== 8'h00 || obs_lo !== 8'h15) begin
         failures++;
         $display("FAIL mul_7x3 got=%h%h exp=0015", obs_hi, obs_lo);
      end
      checks++;
      if (hi_cyc !== 9 || lo_cyc !== 10) begin
         failures++;
         $display("FAIL latency_7x3 got=%0d,%0d exp=9,10", hi_cyc, lo_cyc);
      end
      checks++;
      if (busy_cnt !== 11 || busy_end !== 1'b0) begin
         failures++;
         $display("FAIL busy_7x3 got=%0d/%b exp=11/0", busy_cnt, busy_end);
      end
      checks++;
      if (vcount !== 2 || bus_leak !== 1'b0) begin
         failures++;
         $display("FAIL valid_7x3 got=%0d/%b exp=2/0", vcount, bus_leak);
      end
   endtask

   task automatic test_neg;
      run_op(8'hFB, 8'h06, 1'b0);
      checks++;
      if (obs_hi !== 8'hFF || obs_lo !== 8'hE2) begin
         failures++;
         $display("FAIL mul_m5x6 got=%h%h exp=ffe2", obs_hi, obs_lo);
      end
   endtask

   task automatic test_corners;
      logic [7:0]  am [3] = '{8'h80, 8'h80, 8'h00};
      logic [7:0]  bq [3] = '{8'h80, 8'h7F, 8'h80};
      logic [15:0] ex [3] = '{16'h4000, 16'hC080, 16'h0000};
      for (int i = 0; i < 3; i++) begin
         run_op(am[i], bq[i], 1'b0);
         checks++;
         if ({obs_hi, obs_lo} !== ex[i] || vcount !== 2) begin
            failures++;
            $display("FAIL corner_%0d got=%h%h n=%0d exp=%h n=2", i, obs_hi, obs_lo, vcount, ex[i]);
         end
      end
   endtask

   task automatic test_start_ignored;
      logic [7:0] h2, l2;
      int         n2;
      run_op(8'h02, 8'h02, 1'b1);
      checks++;
      if (obs_hi !== 8'h00 || obs_lo !== 8'h04 || vcount !== 2) begin
         failures++;
         $display("FAIL busy_ignore got=%h%h n=%0d exp=0004 n=2", obs_hi, obs_lo, vcount);
      end
      checks++;
      if (busy_end !== 1'b0) begin
         failures++;
         $display("FAIL busy_ignore_e11 got=%b exp=0", busy_end);
      end
      // start is still high: E12 must accept a new operation with M=0x11.
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL accept_e12 got=%b exp=1", busy);
      end
      start  = 1'b0;
      in_bus = 8'h03;
      h2 = 8'h00;
      l2 = 8'h00;
      n2 = 0;
      for (int c = 1; c <= 11; c++) begin
         @(posedge clk);
         #1;
         in_bus = 8'h00;
         if (out_valid) begin
            n2++;
            if (out_hi) h2 = out_bus;
            else        l2 = out_bus;
         end
      end
      checks++;
      if ({h2, l2} !== ref_prod(8'h11, 8'h03) || n2 !== 2) begin
         failures++;
         $display("FAIL after_e12 got=%h%h n=%0d exp=%h n=2", h2, l2, n2, ref_prod(8'h11, 8'h03));
      end
   endtask

   task automatic test_reset_mid;
      int vseen;
      vseen  = 0;
      start  = 1'b1;
      in_bus = 8'h09;
      @(posedge clk);                 // E0
      #1;
      start  = 1'b0;
      in_bus = 8'h09;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk);
         #1;
         if (out_valid) vseen++;
      end
      // Now in the 4th CALC cycle
      rst = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || out_bus !== 8'h00 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_async got=%b%b/%h exp=00/00", busy, out_valid, out_bus);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         #1;
         if (out_valid) vseen++;
      end
      checks++;
      if (vseen !== 0) begin
         failures++;
         $display("FAIL reset_no_output got=%0d exp=0", vseen);
      end
      run_op(8'h09, 8'h09, 1'b0);
      checks++;
      if (obs_hi !== 8'h00 || obs_lo !== 8'h51 || vcount !== 2) begin
         failures++;
         $display("FAIL after_reset got=%h%h n=%0d exp=0051 n=2", obs_hi, obs_lo, vcount);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0]  m, q;
      logic [15:0] exp_p;
      int          bad;
      bad = 0;
      for (int i = 0; i < 500; i++) begin
         m     = 8'($urandom_range(0, 255));
         q     = 8'($urandom_range(0, 255));
         exp_p = ref_prod(m, q);
         run_op(m, q, 1'b0);
         checks++;
         if ({obs_hi, obs_lo} !== exp_p || vcount !== 2 || hi_cyc !== 9 || lo_cyc !== 10
             || bus_leak !== 1'b0) begin
            failures++;
            bad++;
            if (bad <= 10)
               $display("FAIL rand_%0d m=%h q=%h got=%h%h n=%0d exp=%h n=2",
                        i, m, q, obs_hi, obs_lo, vcount, exp_p);
         end
      end
   endtask

   initial begin
      test_reset();
      test_7x3();
      test_neg();
      test_corners();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/booth_mul.md
# booth_mul

- Sequential signed radix-2 Booth multiplier for the arithmetic datapath. It is the inverse companion of the non-restoring divider.
- It takes two WIDTH-bit two's-complement operands from the shared byte-wide input bus on consecutive cycles.
- It iterates once per clock.
- It returns the 2·WIDTH-bit product on the output bus as two consecutive words, high word first, in the same sequencing style as the divider's quotient/remainder output.

## Interface
- WIDTH, 8, operand width; product is 2·WIDTH bits; iteration counter is ceil(log2(WIDTH)) bits.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE; in_bus carries multiplicand M in the same cycle.
- in_bus  in  WIDTH  operand bus: M in the start cycle, multiplier Q in the following cycle.
- busy  out  1  high from the edge that accepts start until the edge that returns to IDLE.
- out_valid  out  1  out_bus holds a product word.
- out_hi  out  1  qualifies out_valid: 1 means high word, 0 means low word.
- out_bus  out  WIDTH  product word; 0 when out_valid=0.

## Operation
- Registers:
  - M: WIDTH+1 bits, sign-extended.
  - A: WIDTH+1 bits, sign-extended accumulator. The extra bit prevents overflow of A−M when M = −2^(WIDTH−1).
  - Q: WIDTH bits.
  - q_1: 1 bit.
  - cnt: counter.
  - state.
- All registers reset to 0 and state resets to IDLE.
- FSM states: IDLE, LOAD_Q, CALC, OUT_HI, OUT_LO.
- IDLE, start=1: M ← sext(in_bus), A ← 0, q_1 ← 0, cnt ← 0; go to LOAD_Q.
- IDLE, start=0: hold.
- LOAD_Q: Q ← in_bus; go to CALC. start is ignored.
- CALC, one Booth step per cycle:
  - If {Q[0],q_1} = 01: A' = A+M.
  - If {Q[0],q_1} = 10: A' = A−M.
  - Otherwise: A' = A.
  - Then arithmetic right shift of {A',Q,q_1} by 1: A[WIDTH] is replicated, A'[0] goes to Q[WIDTH−1], Q[0] goes to q_1.
  - All add/sub is modulo 2^(WIDTH+1).
  - cnt increments. When cnt = WIDTH−1, go to OUT_HI. Exactly WIDTH steps are performed.
- OUT_HI:
  - Outputs: out_valid=1, out_hi=1, out_bus=A[WIDTH−1:0].
  - Go to OUT_LO.
- OUT_LO:
  - Outputs: out_valid=1, out_hi=0, out_bus=Q.
  - Go to IDLE.
- Product = {A[WIDTH−1:0], Q}, signed. For WIDTH=8 the range is −16256..+16384.
- Outputs are Moore: decoded from the registered state and A/Q only. There is no combinational path from start or in_bus to any output.
- start while busy is ignored, including during OUT_LO. No queuing.
- Reset asserted mid-operation: immediate return to IDLE. busy, out_valid, out_hi and out_bus go to 0 asynchronously. No partial product is ever emitted.
- Reset deassertion: the first start can be sampled at the next rising edge.

## Timing
- Let E0 be the edge that samples start=1 in IDLE.
- E1: Q loaded; busy=1 from E0.
- E2..E(WIDTH+1): Booth steps, which is E2..E9 for WIDTH=8.
- After E(WIDTH+1): high word valid for one cycle.
- After E(WIDTH+2): low word valid for one cycle.
- After E(WIDTH+3): IDLE; busy=0 and out_valid=0.
- For WIDTH=8:
  - Start-to-first-word latency is 9 cycles.
  - Result words are present in the cycles after E9 and E10.
  - busy is high for 11 cycles.
  - Minimum start-to-start spacing is 12 cycles; the next start is sampled at E12.
- The consumer must capture out_bus on each edge where out_valid=1. There is no backpressure.

## Test plan
- 7 × 3, WIDTH=8:
  - start with in_bus=0x07, next cycle in_bus=0x03.
  - Required: out_valid at cycles 9 and 10; words 0x00 (out_hi=1) then 0x15 (out_hi=0); busy falls after E11.
- −5 × 6:
  - Operands 0xFB, 0x06.
  - Required: 0xFF then 0xE2 (−30).
- Corner operands:
  - −128 × −128 (0x80, 0x80) → 0x40, 0x00.
  - −128 × 127 (0x80, 0x7F) → 0xC0, 0x80.
  - 0 × 0x80 → 0x00, 0x00.
- start ignored while busy:
  - start=1 with 0x11 held high during LOAD_Q, CALC, OUT_HI and OUT_LO of a 2 × 2 operation.
  - Required: a single result 0x00, 0x04; the next operation is accepted only at E12.
- Reset mid-operation:
  - rst low for one cycle during the 4th CALC cycle of 9 × 9.
  - Required: out_valid never asserted for that operation; busy=0 and out_bus=0 immediately on rst low.
  - A subsequent 9 × 9 returns 0x00, 0x51.
- Back-to-back randomised:
  - 500 random signed operand pairs issued at 12-cycle spacing.
  - Required: every {high, low} pair equals the signed reference product, with exactly two out_valid cycles per operation.
